dly_tap_ctrl: RTL and testbench
===============================

# dly_tap_ctrl

Sequential select controller for a programmable delay line built from a chain of `mux2` cells. It owns the `S` inputs of every mux2 stage and moves the tap code from its current value to a requested target one LSB at a time. After each single-step change it waits a fixed settle interval, so the delay line never sees a multi-bit select jump mid-operation. It sits directly upstream of the mux2 chain and downstream of the calibration/config logic that issues tap requests.

## Interface
- `N_STAGES`, default 8: number of mux2 stages, equal to the tap code width; stage i select = `sel[i]`.
- `SETTLE_CYC`, default 4: clock cycles to wait after every tap step; legal range ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  tap request present.
- `req_tap`  in  N_STAGES  target tap code, unsigned.
- `req_ready`  out  1  controller idle and accepting a request.
- `sel`  out  N_STAGES  registered tap code driving mux2 `S` pins.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse when `sel` equals the accepted target.

## Operation
- Reset values: `sel`=0, `req_ready`=1, `busy`=0, `done`=0, state IDLE, settle counter 0, latched target 0.
- All outputs are registered or decoded from state registers only. There is no combinational path from `req_*` to `sel`.
- States and transitions:
  - IDLE: `req_ready`=1. Accept when `req_valid && req_ready`. On accept, latch `req_tap` into `target`. If `target == sel`, go to DONE; otherwise go to STEP.
  - STEP: one cycle. At the edge, `sel <= sel+1` if `target > sel`, else `sel <= sel-1`. Load the settle counter with `SETTLE_CYC-1` and go to SETTLE.
  - SETTLE: decrement the counter each cycle. In the cycle where it reads 0, go to DONE if `sel == target`, else go to STEP.
  - DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Arithmetic on `sel` is unsigned. A step never wraps: the step direction is always toward `target`, so 0→max and max→0 are never taken. Settle counter width is `$clog2(SETTLE_CYC)`, minimum 1 bit.
- `req_valid` is ignored while `busy`. A new target cannot preempt a move in progress, and `req_tap` changes while busy have no effect.
- `rst` asserted in any state, including mid-SETTLE, returns everything to reset values at that edge. `sel` goes to 0 in a single jump, which is acceptable only under reset.

## Timing
- Cycle 0 is the accept cycle and d = |target − sel| at accept.
- DONE (`done`=1) occurs in cycle d·(SETTLE_CYC+1)+1. For d=0 this is cycle 1, with no change to `sel`.
- The k-th step (k=1..d) is first visible on `sel` in cycle (k−1)(SETTLE_CYC+1)+2.
- Between consecutive steps, `sel` is held stable for exactly SETTLE_CYC+1 cycles.
- `req_ready` falls in cycle 1 and returns to 1 in the cycle after DONE. The earliest next accept is cycle d·(SETTLE_CYC+1)+2.
- Consecutive `sel` values always differ by exactly 1 LSB. The only exception is reset.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> `sel`=0, `req_ready`=1, `busy`=0, `done`=0.
- Up move, N=4, S=2: from `sel`=0 accept `req_tap`=3 in cycle 0 -> `sel` becomes 1, 2, 3 in cycles 2, 5, 8. `done` pulses in cycle 10 only. `req_ready`=1 again in cycle 11.
- Down move and zero distance, N=4, S=2: from `sel`=3 request 1 -> `sel` 2 at cycle 2, 1 at cycle 5, `done` in cycle 7. Then request 1 again -> `done` in cycle 1, `sel` unchanged.
- Full span, N=4, S=1: request 15 from 0, then 0 from 15 -> 15 single-LSB steps each way, no wrap. `done` in cycle 31 of each move.
- Busy ignore: during a 0→3 move, drive `req_valid`=1 with `req_tap`=0 in cycles 1–9 -> trajectory and `done` timing identical to the up-move case.
- Mid-move reset: assert `rst` in cycle 6 of the 0→3 move -> the next cycle shows `sel`=0, `busy`=0, and no `done`. A fresh request then runs with normal timing.

Source files
------------

// File: rtl/dly_tap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dly_tap_ctrl_if
// Brief    : Request handshake and tap-select bundle for dly_tap_ctrl.
// Revision : 1.0
// ============================================================================
interface dly_tap_ctrl_if #(
  parameter int N_STAGES = 8
);
  logic                req_valid;
  logic [N_STAGES-1:0] req_tap;
  logic                req_ready;
  logic [N_STAGES-1:0] sel;
  logic                busy;
  logic                done;

  // master issues tap requests and observes the select bus
  modport master (
    output req_valid, req_tap,
    input  req_ready, sel, busy, done
  );

  modport slave (
    input  req_valid, req_tap,
    output req_ready, sel, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/dly_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dly_tap_ctrl
// Brief    : Walks a mux2 delay-line tap code to a target one LSB at a time,
//            holding each intermediate code for a fixed settle interval.
// Revision : 1.0
// ============================================================================
module dly_tap_ctrl #(
  parameter int N_STAGES   = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  dly_tap_ctrl_if.slave  bus
);

  localparam int                CNT_W         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  C_SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_STAGES-1:0] C_ONE       = N_STAGES'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_STAGES-1:0] sel_q, sel_d;
  logic [N_STAGES-1:0] target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          target_d = bus.req_tap;
          state_d  = (bus.req_tap == sel_q) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        // Direction always points at the target, so the code never wraps.
        sel_d   = (target_q > sel_q) ? (sel_q + C_ONE) : (sel_q - C_ONE);
        cnt_d   = C_SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = (sel_q == target_q) ? S_DONE : S_STEP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All status outputs decode straight from the state register.
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sel       = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_dly_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dly_tap_ctrl
// Brief    : Randomized self-checking bench for dly_tap_ctrl against a
//            closed-form timing model of each tap move.
// Revision : 1.0
// ============================================================================
module tb_dly_tap_ctrl;

  localparam int N_STAGES = 4;
  localparam int MAX_TAP  = (1 << N_STAGES) - 1;

  logic clk;
  logic rst_a, rst_b;

  dly_tap_ctrl_if #(.N_STAGES(N_STAGES)) bus_a ();
  dly_tap_ctrl_if #(.N_STAGES(N_STAGES)) bus_b ();

  dly_tap_ctrl #(.N_STAGES(N_STAGES), .SETTLE_CYC(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  dly_tap_ctrl #(.N_STAGES(N_STAGES), .SETTLE_CYC(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int model_sel [2];

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic set_req(input int w, input bit v, input int tap);
    if (w == 0) begin
      bus_a.req_valid = v;
      bus_a.req_tap   = N_STAGES'(tap);
    end else begin
      bus_b.req_valid = v;
      bus_b.req_tap   = N_STAGES'(tap);
    end
  endtask

  task automatic set_rst(input int w, input bit v);
    if (w == 0) rst_a = v;
    else        rst_b = v;
  endtask

  task automatic sample(input int w, output int s, output int r, output int b, output int d);
    if (w == 0) begin
      s = int'(bus_a.sel); r = int'(bus_a.req_ready); b = int'(bus_a.busy); d = int'(bus_a.done);
    end else begin
      s = int'(bus_b.sel); r = int'(bus_b.req_ready); b = int'(bus_b.busy); d = int'(bus_b.done);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from the current code to tgt. junk_tap >= 0 drives req_valid
  // with that tap while busy; rst_at > 0 asserts reset in that cycle.
  task automatic do_move(input int w, input int tgt, input int junk_tap,
                         input int rst_at, input string tag);
    int s      = (w == 0) ? 2 : 1;
    int s0     = model_sel[w];
    int d      = (tgt > s0) ? (tgt - s0) : (s0 - tgt);
    int dir    = (tgt >= s0) ? 1 : -1;
    int done_c = d * (s + 1) + 1;
    int o_sel, o_rdy, o_busy, o_done;
    int k;

    sample(w, o_sel, o_rdy, o_busy, o_done);
    check($sformatf("%s_c0_ready", tag), o_rdy, 1);
    check($sformatf("%s_c0_sel", tag), o_sel, s0);
    set_req(w, 1'b1, tgt);

    for (int c = 1; c <= done_c + 1; c++) begin
      tick();
      sample(w, o_sel, o_rdy, o_busy, o_done);
      k = (c < 2) ? 0 : ((c - 2) / (s + 1) + 1);
      if (k > d) k = d;
      check($sformatf("%s_c%0d_sel", tag, c), o_sel, s0 + dir * k);
      check($sformatf("%s_c%0d_done", tag, c), o_done, (c == done_c) ? 1 : 0);
      check($sformatf("%s_c%0d_busy", tag, c), o_busy, (c <= done_c) ? 1 : 0);
      check($sformatf("%s_c%0d_ready", tag, c), o_rdy, (c <= done_c) ? 0 : 1);

      if (junk_tap >= 0 && c <= done_c) set_req(w, 1'b1, junk_tap);
      else                              set_req(w, 1'b0, 0);

      if (rst_at > 0 && c == rst_at) begin
        set_rst(w, 1'b1);
        tick();
        set_rst(w, 1'b0);
        sample(w, o_sel, o_rdy, o_busy, o_done);
        check($sformatf("%s_rst_sel", tag), o_sel, 0);
        check($sformatf("%s_rst_busy", tag), o_busy, 0);
        check($sformatf("%s_rst_done", tag), o_done, 0);
        check($sformatf("%s_rst_ready", tag), o_rdy, 1);
        model_sel[w] = 0;
        return;
      end
    end
    model_sel[w] = tgt;
  endtask

  task automatic idle_gap(input int w, input int n, input string tag);
    int o_sel, o_rdy, o_busy, o_done;
    set_req(w, 1'b0, int'($urandom_range(0, MAX_TAP)));
    for (int i = 0; i < n; i++) begin
      tick();
      sample(w, o_sel, o_rdy, o_busy, o_done);
      check($sformatf("%s_gap_sel", tag), o_sel, model_sel[w]);
      check($sformatf("%s_gap_done", tag), o_done, 0);
    end
  endtask

  initial begin
    int o_sel, o_rdy, o_busy, o_done;
    int tgt, jt;

    model_sel[0] = 0;
    model_sel[1] = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_req(0, 1'b0, 0);
    set_req(1, 1'b0, 0);

    for (int i = 0; i < 2; i++) begin
      set_req(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, MAX_TAP)));
      set_req(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, MAX_TAP)));
      tick();
    end
    for (int w = 0; w < 2; w++) begin
      sample(w, o_sel, o_rdy, o_busy, o_done);
      check($sformatf("reset%0d_sel", w), o_sel, 0);
      check($sformatf("reset%0d_ready", w), o_rdy, 1);
      check($sformatf("reset%0d_busy", w), o_busy, 0);
      check($sformatf("reset%0d_done", w), o_done, 0);
    end
    set_req(0, 1'b0, 0);
    set_req(1, 1'b0, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    do_move(0, 3, -1, 0, "up");
    do_move(0, 1, -1, 0, "down");
    do_move(0, 1, -1, 0, "zero");

    do_move(1, 15, -1, 0, "span_up");
    do_move(1, 0, -1, 0, "span_dn");

    do_move(0, 0, -1, 0, "prep0");
    do_move(0, 3, 0, 0, "busy_ign");

    do_move(0, 0, -1, 0, "prep1");
    do_move(0, 3, -1, 6, "mid_rst");
    do_move(0, 3, -1, 0, "post_rst");

    for (int i = 0; i < 20; i++) begin
      idle_gap(0, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      tgt = int'($urandom_range(0, MAX_TAP));
      jt  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAX_TAP)) : -1;
      do_move(0, tgt, jt, 0, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      idle_gap(1, int'($urandom_range(0, 2)), $sformatf("rndb%0d", i));
      tgt = int'($urandom_range(0, MAX_TAP));
      jt  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAX_TAP)) : -1;
      do_move(1, tgt, jt, 0, $sformatf("rndb%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
